fifo_key_ctrl: RTL
==================

// Module: fifo_key_ctrl
// PURPOSE
//   Upstream input stage for the 4-bit FIFO: conditions the board's read/write push-buttons and 4 data switches.
//   Synchronises and debounces each key, emits one-clock read/write strobes, and captures switch data for writes.
//   Suppresses strobes the FIFO cannot accept (write when full, read when empty) and flags them.
//   Outputs drive the FIFO's read, write and fifo_in inputs directly, in the same clock domain.
// PARAMETERS
//   WIDTH         4        data switch / fifo_in width
//   DEB_LIMIT     1000000  stable cycles required to accept a press or release (20 ms @ 50 MHz)
//   DEB_CNT_W     20       debounce counter width; must satisfy 2**DEB_CNT_W > DEB_LIMIT
//   REPEAT_DELAY  25000000 cycles held before the first auto-repeat (KEY_AUTOREPEAT_EN only)
//   REPEAT_PERIOD 5000000  cycles between later auto-repeats (KEY_AUTOREPEAT_EN only)
// PORTS
//   clock       in   1      system clock
//   reset       in   1      asynchronous, active-high reset
//   key_read_n  in   1      read push-button, active-low, asynchronous
//   key_write_n in   1      write push-button, active-low, asynchronous
//   sw_in       in   WIDTH  data switches, asynchronous
//   fifo_full   in   1      FIFO full flag
//   fifo_empty  in   1      FIFO empty flag
//   read        out  1      one-cycle read strobe to FIFO
//   write       out  1      one-cycle write strobe to FIFO
//   fifo_in     out  WIDTH  write data, valid while write=1, held otherwise
//   drop        out  1      one-cycle pulse: strobe suppressed (full/empty)
// BEHAVIOUR
//   - Reset (asynchronous): all outputs 0, fifo_in 0, sync flops 1 (released), FSMs IDLE, counters 0.
//   - Sync: key_*_n and sw_in each pass through 2 flops. All logic uses synced copies only.
//   - Per-key FSM (pressed = synced key 0):
//       IDLE        : pressed -> DEB_PRESS, cnt<=0.
//       DEB_PRESS   : released -> IDLE; else cnt++. When cnt==DEB_LIMIT-1 -> PRESSED and raise pulse.
//       PRESSED     : released -> DEB_RELEASE, cnt<=0.
//       DEB_RELEASE : pressed -> PRESSED (no pulse); else cnt++. When cnt==DEB_LIMIT-1 -> IDLE.
//   - Each FSM pulse is high for exactly one cycle per accepted press. Bounces shorter than DEB_LIMIT never pulse.
//   - Output regs: write <= wpulse & ~fifo_full; read <= rpulse & ~fifo_empty.
//     drop <= (wpulse & fifo_full) | (rpulse & fifo_empty).
//     Strobes are registered: 1-cycle latency after the FSM pulse.
//   - fifo_in <= synced sw_in on the same edge write rises; otherwise it holds its value.
//   - Both keys accepted in the same cycle: read and write are both 1 (FIFO handles the simultaneous case).
//     Gating for each strobe is independent.
//   - Flags are sampled in the pulse cycle. A write and a read are never merged or queued.
//   - Reset mid-debounce or while held: FSM goes to IDLE. A key still held after reset needs a full DEB_LIMIT
//     before it pulses again.
//   - Counters saturate at DEB_LIMIT-1 and never wrap.
// CONFIGURATION
//   KEY_AUTOREPEAT_EN defined:
//     - In PRESSED, a repeat counter raises an extra pulse after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
//     - The counter clears on leaving PRESSED. Extra pulses are gated and dropped exactly like normal pulses.
//   KEY_AUTOREPEAT_EN undefined: exactly one pulse per press; no repeat counter or logic is synthesised.
// STRUCTURE
//   - Package fifo_key_pkg:
//       key_state_t enum {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} (2-bit encoding)
//       default DEB_LIMIT / REPEAT_* constants
//   - Sub-module key_debounce (sync + FSM + counter + optional repeat) instantiated twice (read, write).
//   - Top level holds the switch synchroniser, fifo_in capture, full/empty gating and the drop logic.
// TESTING (bench uses DEB_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1. Write press:
//      key_write_n low 10 cycles, sw_in=4'hA, fifo_full=0 -> write=1 for exactly 1 cycle, fifo_in=4'hA.
//      write rises at cycle 2(sync)+4(deb)+1(reg) after the key edge.
//   2. Bounce: key_write_n toggles low 3 / high 1 cycle, five times, then stays high -> write never asserts, drop=0.
//   3. Full gating: fifo_full=1, clean write press -> write stays 0, drop=1 for 1 cycle, fifo_in unchanged.
//      Same for read with fifo_empty=1.
//   4. Simultaneous: both keys low on the same cycle, not full, not empty -> read=write=1 in the same single cycle.
//   5. Reset mid-debounce: assert reset 2 cycles into DEB_PRESS with key held -> outputs 0 at once.
//      After reset release, write pulses only after a fresh 2+4+1 cycles.
//   6. KEY_AUTOREPEAT_EN: hold write 40 cycles -> pulses at the first accept, +10, then every 3 cycles;
//      none after release. Without the macro -> exactly 1 pulse.

Source files
------------

// File: rtl/fifo_key_pkg.sv
// Shared types and default timing constants for the FIFO key/switch input stage.
package fifo_key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_DEB_LIMIT     = 1000000;   // 20 ms at 50 MHz
  localparam int DEF_DEB_CNT_W     = 20;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM and a one-cycle accept pulse.
// KEY_AUTOREPEAT_EN adds auto-repeat pulses while the key stays held.
module key_debounce
  import fifo_key_pkg::*;
#(
  parameter int DEB_LIMIT     = DEF_DEB_LIMIT,
  parameter int DEB_CNT_W     = DEF_DEB_CNT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEB_LIMIT - 1);

  logic key_s1, key_s2;
  logic pressed;
  key_state_t state, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic acc_pulse;

  // Sync flops reset to 1 so a key held through reset is seen as a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  assign pressed = ~key_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q;
    acc_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PRESSED;
          acc_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_q;
  logic rep_armed_q;
  logic rep_pulse;

  // First repeat after REPEAT_DELAY held cycles, later ones every REPEAT_PERIOD.
  always_comb begin
    rep_pulse = 1'b0;
    if (state == PRESSED && pressed) begin
      if (rep_armed_q) rep_pulse = (rep_q == REP_W'(REPEAT_PERIOD - 1));
      else             rep_pulse = (rep_q == REP_W'(REPEAT_DELAY - 1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else if (state != PRESSED || !pressed) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else if (rep_pulse) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end

  assign pulse = acc_pulse | rep_pulse;
`else
  assign pulse = acc_pulse;
`endif

endmodule

// File: rtl/fifo_key_ctrl.sv
// FIFO input stage: debounced read/write strobes, switch capture, full/empty gating and drop flag.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat on held keys.
module fifo_key_ctrl
  import fifo_key_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEB_LIMIT     = DEF_DEB_LIMIT,
  parameter int DEB_CNT_W     = DEF_DEB_CNT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_read_n,
  input  logic             key_write_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             read,
  output logic             write,
  output logic [WIDTH-1:0] fifo_in,
  output logic             drop
);

  logic rpulse, wpulse;
  logic [WIDTH-1:0] sw_s1, sw_s2;
  logic wr_ok, rd_ok;

  key_debounce #(
    .DEB_LIMIT    (DEB_LIMIT),
    .DEB_CNT_W    (DEB_CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rd_key (
    .clock(clock),
    .reset(reset),
    .key_n(key_read_n),
    .pulse(rpulse)
  );

  key_debounce #(
    .DEB_LIMIT    (DEB_LIMIT),
    .DEB_CNT_W    (DEB_CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_wr_key (
    .clock(clock),
    .reset(reset),
    .key_n(key_write_n),
    .pulse(wpulse)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

  // Flags are sampled in the pulse cycle; each strobe is gated independently.
  assign wr_ok = wpulse & ~fifo_full;
  assign rd_ok = rpulse & ~fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read    <= 1'b0;
      write   <= 1'b0;
      drop    <= 1'b0;
      fifo_in <= '0;
    end else begin
      write <= wr_ok;
      read  <= rd_ok;
      drop  <= (wpulse & fifo_full) | (rpulse & fifo_empty);
      if (wr_ok) fifo_in <= sw_s2;
    end
  end

endmodule
